arch_map_table: RTL and testbench
=================================

// Module: arch_map_table
// PURPOSE
// - Retirement-side architectural map table (AMT). Sits between the active list's commit
//   logic and the speculative free list.
// - Up to 4 instructions retire per cycle. For each one, it records the committed
//   logical->physical mapping and returns the previously committed physical register.
// - Returned registers drive the free list's commitValidN_i/commitRegN_i one cycle later.
// - Exports the full committed map so the rename map table can restore it on a full flush.
// PARAMETERS
// - SIZE_RMT           32  number of logical registers (table entries)
// - SIZE_RMT_LOG        5  log2(SIZE_RMT)
// - SIZE_PHYSICAL_LOG   7  physical register tag width
// - COMMIT_WIDTH        4  retire slots per cycle; slot 0 is oldest
// PORTS
// - clk               in   1                            clock
// - reset             in   1                            asynchronous, active-high
// - commitValidN_i    in   1 (N=0..3)                   slot N retires this cycle
// - commitHasDestN_i  in   1 (N=0..3)                   slot N writes a logical register
// - commitLogDestN_i  in   SIZE_RMT_LOG (N=0..3)        logical destination of slot N
// - commitPhyDestN_i  in   SIZE_PHYSICAL_LOG (N=0..3)   physical destination of slot N
// - releaseValidN_o   out  1 (N=0..3)                   registered; slot N frees a register
// - releaseRegN_o     out  SIZE_PHYSICAL_LOG (N=0..3)   registered; tag to return to free list
// - releaseCnt_o      out  3                            registered; popcount of releaseValid
// - amtMap_o          out  SIZE_RMT*SIZE_PHYSICAL_LOG   committed map; entry i at bits [i*P +: P]
// BEHAVIOUR
// - Reset (async, immediate):
//   - map[i] = i for all i, so physical tags 0..SIZE_RMT-1 are committed.
//   - All releaseValidN_o = 0, releaseRegN_o = 0, releaseCnt_o = 0.
// - Active slot: commitValidN_i & commitHasDestN_i. Inactive slots neither read nor write the map.
// - Release tag for active slot N = the value seen just before slot N in program order:
//   - The commitPhyDestM_i of the youngest active slot M<N with the same logical dest, if one exists.
//   - Otherwise map[commitLogDestN_i] as held at the start of the cycle.
// - Map update at the clock edge: for each logical reg, the youngest active writer in the group wins.
//   Entries with no writer hold their value.
// - Release latency is 1 cycle. Slot positions are preserved, not compacted, and they are not
//   re-sorted; the free list handles sparse valids.
//   - releaseValidN_o(t+1) = active slot N(t).
//   - releaseRegN_o(t+1) = release tag N(t) when active, else 0.
// - amtMap_o is combinational from the state registers only: it reflects all commits up to the
//   previous edge and never includes same-cycle inputs.
// - No stall or flush input. Retirement is architectural and never cancelled. A recovery in the
//   same cycle as a commit does not suppress the update; the RMT samples amtMap_o one cycle after
//   the last commit.
// - Logical reg 0 is mapped like any other register. Commit logic deasserts HasDest for writes
//   that must not rename it.
// - Duplicate physical tags in one group are a protocol violation; behaviour is unspecified and a
//   simulation assertion fires.
// - Reset mid-operation: the pending registered releases are discarded, not delivered. The free
//   list resets in the same cycle, so no tag leaks.
// STRUCTURE
// - Shared package: SIZE_RMT, SIZE_RMT_LOG, SIZE_PHYSICAL_LOG, COMMIT_WIDTH, and the commit-slot
//   struct {valid, hasDest, logDest, phyDest}.
// - Sub-module amt_bypass_chain: combinational intra-group dependency check. Takes 4 slots plus
//   4 table reads and produces 4 release tags plus 4 per-slot "youngest writer" flags.
// - Top level: flip-flop map array with 4 read ports, the release pipeline register, and
//   update/popcount logic.
// TESTING
// - Reset, then one commit with slot0 active (log 5 -> phy 40) -> next cycle releaseValid0=1,
//   releaseReg0=5, releaseCnt=1, map[5]=40.
// - Same cycle: slot0 log3->phy50, slot1 log3->phy51 -> releaseReg0=3, releaseReg1=50, map[3]=51.
// - valid=4'b1010 with slots 1 and 3 on distinct regs -> releaseValid=4'b1010, releaseCnt=2;
//   slots 0 and 2 read as 0.
// - Slot2 valid but HasDest=0 -> releaseValid2=0 and the map is unchanged.
// - All 4 slots write log7 with phy 60..63 -> releases {7,60,61,62}, map[7]=63.
// - Assert reset while releases are pending -> outputs go to 0 immediately, amtMap_o returns to
//   identity, and no release appears after reset deasserts.

Source files
------------

// File: rtl/arch_map_table_pkg.sv
// Purpose: shared sizing constants, the commit-slot struct and a small popcount
//          helper for the retirement-side architectural map table.
// Contents:
//   SIZE_RMT / SIZE_RMT_LOG     logical register count and index width
//   SIZE_PHYSICAL_LOG           physical register tag width
//   COMMIT_WIDTH                retire slots per cycle (slot 0 oldest)
//   commit_slot_t               {valid, hasDest, logDest, phyDest}
//   popcnt_commit()             number of set bits in a COMMIT_WIDTH vector
package arch_map_table_pkg;

    localparam int SIZE_RMT          = 32;
    localparam int SIZE_RMT_LOG      = 5;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int COMMIT_WIDTH      = 4;

    typedef struct packed {
        logic                         valid;
        logic                         hasDest;
        logic [SIZE_RMT_LOG-1:0]      logDest;
        logic [SIZE_PHYSICAL_LOG-1:0] phyDest;
    } commit_slot_t;

    function automatic logic [2:0] popcnt_commit(input logic [COMMIT_WIDTH-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/arch_map_table_bypass_chain.sv
// Purpose: combinational intra-group dependency resolution for one retire group.
//          For every slot it picks the physical tag the slot displaces (an older
//          same-group writer of the same logical reg, else the table read), and
//          flags whether the slot is the youngest writer of its logical reg.
// Ports:
//   slot_i      in   COMMIT_WIDTH commit slots, slot 0 oldest
//   rdData_i    in   map contents at slot N's logical dest, start of cycle
//   active_o    out  slot N is valid and writes a destination
//   relTag_o    out  tag slot N returns to the free list
//   youngest_o  out  slot N is the last active writer of its logical reg
module amt_bypass_chain
    import arch_map_table_pkg::*;
(
    input  commit_slot_t [COMMIT_WIDTH-1:0]                         slot_i,
    input  logic         [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] rdData_i,
    output logic         [COMMIT_WIDTH-1:0]                         active_o,
    output logic         [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] relTag_o,
    output logic         [COMMIT_WIDTH-1:0]                         youngest_o
);

    always_comb begin
        active_o   = '0;
        relTag_o   = rdData_i;
        youngest_o = '0;

        for (int n = 0; n < COMMIT_WIDTH; n++) begin
            active_o[n] = slot_i[n].valid & slot_i[n].hasDest;
        end

        for (int n = 0; n < COMMIT_WIDTH; n++) begin
            // Walk older slots oldest->youngest so the last match (youngest older) wins.
            for (int m = 0; m < n; m++) begin
                if (active_o[m] && (slot_i[m].logDest == slot_i[n].logDest)) begin
                    relTag_o[n] = slot_i[m].phyDest;
                end
            end
            youngest_o[n] = active_o[n];
            for (int m = n + 1; m < COMMIT_WIDTH; m++) begin
                if (active_o[m] && (slot_i[m].logDest == slot_i[n].logDest)) begin
                    youngest_o[n] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/arch_map_table.sv
// Purpose: retirement-side architectural map table. Records committed
//          logical->physical mappings for up to COMMIT_WIDTH retiring instructions
//          per cycle and returns each displaced physical tag one cycle later.
// Ports:
//   clk, reset                   clock; asynchronous active-high reset
//   commitValidN_i               slot N retires this cycle
//   commitHasDestN_i             slot N writes a logical register
//   commitLogDestN_i             logical destination of slot N
//   commitPhyDestN_i             physical destination of slot N
//   releaseValidN_o              registered; slot N frees a register
//   releaseRegN_o                registered; tag to return to the free list
//   releaseCnt_o                 registered; popcount of the release valids
//   amtMap_o                     committed map, entry i at bits [i*P +: P]
module arch_map_table
    import arch_map_table_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  commitValid0_i,
    input  logic                                  commitValid1_i,
    input  logic                                  commitValid2_i,
    input  logic                                  commitValid3_i,
    input  logic                                  commitHasDest0_i,
    input  logic                                  commitHasDest1_i,
    input  logic                                  commitHasDest2_i,
    input  logic                                  commitHasDest3_i,
    input  logic [SIZE_RMT_LOG-1:0]               commitLogDest0_i,
    input  logic [SIZE_RMT_LOG-1:0]               commitLogDest1_i,
    input  logic [SIZE_RMT_LOG-1:0]               commitLogDest2_i,
    input  logic [SIZE_RMT_LOG-1:0]               commitLogDest3_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]          commitPhyDest0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]          commitPhyDest1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]          commitPhyDest2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]          commitPhyDest3_i,
    output logic                                  releaseValid0_o,
    output logic                                  releaseValid1_o,
    output logic                                  releaseValid2_o,
    output logic                                  releaseValid3_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]          releaseReg0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]          releaseReg1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]          releaseReg2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]          releaseReg3_o,
    output logic [2:0]                            releaseCnt_o,
    output logic [SIZE_RMT*SIZE_PHYSICAL_LOG-1:0] amtMap_o
);

    commit_slot_t [COMMIT_WIDTH-1:0]                         slot;
    logic         [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] rdData;
    logic         [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] relTag;
    logic         [COMMIT_WIDTH-1:0]                         active;
    logic         [COMMIT_WIDTH-1:0]                         youngest;

    logic [SIZE_RMT-1:0][SIZE_PHYSICAL_LOG-1:0]     map_q, map_d;
    logic [COMMIT_WIDTH-1:0]                        relValid_q, relValid_d;
    logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] relReg_q, relReg_d;
    logic [2:0]                                     relCnt_q, relCnt_d;

    assign slot[0] = '{commitValid0_i, commitHasDest0_i, commitLogDest0_i, commitPhyDest0_i};
    assign slot[1] = '{commitValid1_i, commitHasDest1_i, commitLogDest1_i, commitPhyDest1_i};
    assign slot[2] = '{commitValid2_i, commitHasDest2_i, commitLogDest2_i, commitPhyDest2_i};
    assign slot[3] = '{commitValid3_i, commitHasDest3_i, commitLogDest3_i, commitPhyDest3_i};

    // Four read ports into the start-of-cycle table.
    always_comb begin
        for (int n = 0; n < COMMIT_WIDTH; n++) begin
            rdData[n] = map_q[slot[n].logDest];
        end
    end

    amt_bypass_chain u_bypass (
        .slot_i     (slot),
        .rdData_i   (rdData),
        .active_o   (active),
        .relTag_o   (relTag),
        .youngest_o (youngest)
    );

    always_comb begin
        map_d      = map_q;
        relValid_d = active;
        relReg_d   = '0;
        for (int n = 0; n < COMMIT_WIDTH; n++) begin
            if (youngest[n]) map_d[slot[n].logDest] = slot[n].phyDest;
            if (active[n])   relReg_d[n] = relTag[n];
        end
        relCnt_d = popcnt_commit(active);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE_RMT; i++) begin
                map_q[i] <= SIZE_PHYSICAL_LOG'(i);
            end
            relValid_q <= '0;
            relReg_q   <= '0;
            relCnt_q   <= '0;
        end else begin
            map_q      <= map_d;
            relValid_q <= relValid_d;
            relReg_q   <= relReg_d;
            relCnt_q   <= relCnt_d;
        end
    end

    assign releaseValid0_o = relValid_q[0];
    assign releaseValid1_o = relValid_q[1];
    assign releaseValid2_o = relValid_q[2];
    assign releaseValid3_o = relValid_q[3];
    assign releaseReg0_o   = relReg_q[0];
    assign releaseReg1_o   = relReg_q[1];
    assign releaseReg2_o   = relReg_q[2];
    assign releaseReg3_o   = relReg_q[3];
    assign releaseCnt_o    = relCnt_q;
    // Packed [entry][bit] flattens so entry i lands at bits [i*P +: P].
    assign amtMap_o        = map_q;

`ifndef SYNTHESIS
    logic dupPhy;
    always_comb begin
        dupPhy = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
                if (active[i] && active[j] && (slot[i].phyDest == slot[j].phyDest)) dupPhy = 1'b1;
            end
        end
    end

    a_no_dup_phy: assert property (@(posedge clk) disable iff (reset) !dupPhy)
        else $error("arch_map_table: duplicate physical tag within one retire group");
`endif

endmodule

// File: tb/tb_arch_map_table.sv
module tb_arch_map_table;
    import arch_map_table_pkg::*;

    localparam int P = SIZE_PHYSICAL_LOG;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] cv, ch;
    logic [3:0][SIZE_RMT_LOG-1:0] cl;
    logic [3:0][P-1:0] cp;
    logic rv0, rv1, rv2, rv3;
    logic [P-1:0] rr0, rr1, rr2, rr3;
    logic [2:0] rcnt;
    logic [SIZE_RMT*P-1:0] amap;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    arch_map_table dut (
        .clk(clk), .reset(reset),
        .commitValid0_i(cv[0]), .commitValid1_i(cv[1]), .commitValid2_i(cv[2]), .commitValid3_i(cv[3]),
        .commitHasDest0_i(ch[0]), .commitHasDest1_i(ch[1]), .commitHasDest2_i(ch[2]), .commitHasDest3_i(ch[3]),
        .commitLogDest0_i(cl[0]), .commitLogDest1_i(cl[1]), .commitLogDest2_i(cl[2]), .commitLogDest3_i(cl[3]),
        .commitPhyDest0_i(cp[0]), .commitPhyDest1_i(cp[1]), .commitPhyDest2_i(cp[2]), .commitPhyDest3_i(cp[3]),
        .releaseValid0_o(rv0), .releaseValid1_o(rv1), .releaseValid2_o(rv2), .releaseValid3_o(rv3),
        .releaseReg0_o(rr0), .releaseReg1_o(rr1), .releaseReg2_o(rr2), .releaseReg3_o(rr3),
        .releaseCnt_o(rcnt), .amtMap_o(amap)
    );

    function automatic logic [31:0] ment(input int i);
        return 32'(amap[i*P +: P]);
    endfunction

    function automatic logic [31:0] rvs();
        return {28'd0, rv3, rv2, rv1, rv0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cv = '0; ch = '0; cl = '0; cp = '0;
    endtask

    task automatic slot(input int n, input logic v, input logic h,
                        input logic [SIZE_RMT_LOG-1:0] l, input logic [P-1:0] p);
        cv[n] = v; ch[n] = h; cl[n] = l; cp[n] = p;
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        #2;
        chk("rst_valid", rvs(), 0);
        chk("rst_cnt", 32'(rcnt), 0);
        chk("rst_reg0", 32'(rr0), 0);
        chk("rst_map0", ment(0), 0);
        chk("rst_map5", ment(5), 5);
        chk("rst_map31", ment(31), 31);
        step();
        reset = 1'b0;
        step();
        chk("idle_valid", rvs(), 0);

        // single commit 5 -> 40
        slot(0, 1, 1, 5, 40);
        #1;
        chk("map5_no_same_cycle", ment(5), 5);
        step();
        clr();
        chk("t1_valid", rvs(), 4'b0001);
        chk("t1_reg0", 32'(rr0), 5);
        chk("t1_cnt", 32'(rcnt), 1);
        chk("t1_map5", ment(5), 40);
        step();
        chk("t1_drain_valid", rvs(), 0);
        chk("t1_drain_cnt", 32'(rcnt), 0);

        // same-group dependency on log 3
        slot(0, 1, 1, 3, 50);
        slot(1, 1, 1, 3, 51);
        step();
        clr();
        chk("t2_valid", rvs(), 4'b0011);
        chk("t2_reg0", 32'(rr0), 3);
        chk("t2_reg1", 32'(rr1), 50);
        chk("t2_cnt", 32'(rcnt), 2);
        chk("t2_map3", ment(3), 51);

        // sparse valids; invalid slots carry junk that must be ignored
        slot(0, 0, 1, 10, 99);
        slot(1, 1, 1, 10, 70);
        slot(2, 0, 1, 11, 98);
        slot(3, 1, 1, 11, 71);
        step();
        clr();
        chk("t3_valid", rvs(), 4'b1010);
        chk("t3_cnt", 32'(rcnt), 2);
        chk("t3_reg0", 32'(rr0), 0);
        chk("t3_reg1", 32'(rr1), 10);
        chk("t3_reg2", 32'(rr2), 0);
        chk("t3_reg3", 32'(rr3), 11);
        chk("t3_map10", ment(10), 70);
        chk("t3_map11", ment(11), 71);

        // valid without destination
        slot(2, 1, 0, 12, 80);
        step();
        clr();
        chk("t4_valid", rvs(), 0);
        chk("t4_reg2", 32'(rr2), 0);
        chk("t4_cnt", 32'(rcnt), 0);
        chk("t4_map12", ment(12), 12);

        // four writers of log 7
        slot(0, 1, 1, 7, 60);
        slot(1, 1, 1, 7, 61);
        slot(2, 1, 1, 7, 62);
        slot(3, 1, 1, 7, 63);
        step();
        clr();
        chk("t5_valid", rvs(), 4'b1111);
        chk("t5_cnt", 32'(rcnt), 4);
        chk("t5_reg0", 32'(rr0), 7);
        chk("t5_reg1", 32'(rr1), 60);
        chk("t5_reg2", 32'(rr2), 61);
        chk("t5_reg3", 32'(rr3), 62);
        chk("t5_map7", ment(7), 63);

        // mixed: interleaved regs against previously committed state
        slot(0, 1, 1, 5, 90);
        slot(1, 1, 1, 3, 91);
        slot(2, 1, 1, 5, 92);
        slot(3, 1, 1, 20, 93);
        step();
        clr();
        chk("t6_reg0", 32'(rr0), 40);
        chk("t6_reg1", 32'(rr1), 51);
        chk("t6_reg2", 32'(rr2), 90);
        chk("t6_reg3", 32'(rr3), 20);
        chk("t6_map5", ment(5), 92);
        chk("t6_map3", ment(3), 91);
        chk("t6_map20", ment(20), 93);

        // reset with releases pending
        slot(0, 1, 1, 1, 100);
        step();
        chk("t7_pending", rvs(), 4'b0001);
        slot(0, 1, 1, 2, 101);
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", rvs(), 0);
        chk("t7_rst_cnt", 32'(rcnt), 0);
        chk("t7_rst_reg0", 32'(rr0), 0);
        chk("t7_rst_map1", ment(1), 1);
        chk("t7_rst_map7", ment(7), 7);
        step();
        reset = 1'b0;
        clr();
        step();
        chk("t7_post_valid", rvs(), 0);
        chk("t7_post_cnt", 32'(rcnt), 0);
        chk("t7_post_map2", ment(2), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
